// File: rtl/calc_pkg.sv
// Shared key/status codes, sequencer state encoding and small helpers for the
// calculator keypad sequencer.
package calc_pkg;

    localparam logic [3:0] CMD_ADD  = 4'hA;
    localparam logic [3:0] CMD_SUB  = 4'hB;
    localparam logic [3:0] CMD_MUL  = 4'hC;
    localparam logic [3:0] CMD_NOP  = 4'hD;
    localparam logic [3:0] CMD_EQ   = 4'hE;
    localparam logic [3:0] CMD_BKSP = 4'hF;

    localparam logic [1:0] STAT_IDLE = 2'b00;
    localparam logic [1:0] STAT_BUSY = 2'b01;
    localparam logic [1:0] STAT_DONE = 2'b10;
    localparam logic [1:0] STAT_ERR  = 2'b11;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CHECK    = 4'd1,
        ST_CONV_A   = 4'd2,
        ST_CONV_B   = 4'd3,
        ST_SEND_A   = 4'd4,
        ST_SEND_OP  = 4'd5,
        ST_SEND_B   = 4'd6,
        ST_SEND_EQ  = 4'd7,
        ST_WAIT_RES = 4'd8,
        ST_FINISH   = 4'd9
    } seq_state_t;

    // Operator select to key code; the illegal encoding maps to a harmless NOP.
    function automatic logic [3:0] op_code(input logic [1:0] sel);
        logic [3:0] code;
        case (sel)
            OP_ADD:  code = CMD_ADD;
            OP_SUB:  code = CMD_SUB;
            OP_MUL:  code = CMD_MUL;
            default: code = CMD_NOP;
        endcase
        return code;
    endfunction

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble converter: the start cycle performs the first shift,
// so a conversion takes exactly WIDTH cycles and done pulses right after.
module bin_to_bcd #(
    parameter int WIDTH  = 27,
    parameter int DIGITS = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shift_r;
    logic [BW-1:0]    bcd_r;
    logic [BW-1:0]    adj_s;
    logic [CW-1:0]    cnt_r;
    logic             done_r;

    // Add-3 correction on every BCD digit that is 5 or more before the shift.
    always_comb begin
        adj_s = bcd_r;
        for (int d = 0; d < DIGITS; d++) begin
            adj_s[4*d +: 4] = (bcd_r[4*d +: 4] >= 4'd5) ? (bcd_r[4*d +: 4] + 4'd3)
                                                        : bcd_r[4*d +: 4];
        end
    end

    // Shift engine: load-and-first-shift on start, then WIDTH-1 further shifts.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_r <= '0;
            bcd_r   <= '0;
            cnt_r   <= '0;
            done_r  <= 1'b0;
        end else if (start) begin
            bcd_r   <= {{(BW-1){1'b0}}, bin[WIDTH-1]};
            shift_r <= {bin[WIDTH-2:0], 1'b0};
            cnt_r   <= CW'(WIDTH - 1);
            done_r  <= 1'b0;
        end else if (cnt_r != '0) begin
            bcd_r   <= {adj_s[BW-2:0], shift_r[WIDTH-1]};
            shift_r <= {shift_r[WIDTH-2:0], 1'b0};
            cnt_r   <= cnt_r - CW'(1);
            done_r  <= (cnt_r == CW'(1));
        end else begin
            done_r  <= 1'b0;
        end
    end

    assign done = done_r;
    assign bcd  = bcd_r;

endmodule

// File: rtl/calc_key_sequencer.sv
// Keypad transmitter for calc_top: converts two operands to decimal and plays
// "A op B =" on cmd with fixed hold/gap timing, then waits for the result.
module calc_key_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH          = 27,
    parameter int DIGITS         = 8,
    parameter int HOLD_CYCLES    = 10,
    parameter int GAP_CYCLES     = 2,
    parameter int RESULT_TIMEOUT = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       op_sel,
    output logic [3:0]       cmd,
    input  logic [1:0]       status,
    output logic             busy,
    output logic             done,
    output logic             result_ok,
    output logic             req_error
);

    localparam int BW      = 4 * DIGITS;
    localparam int DIW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int KEY_CYC = HOLD_CYCLES + GAP_CYCLES;
    localparam int TW      = $clog2(KEY_CYC + 1);
    localparam int WW      = $clog2(RESULT_TIMEOUT + 1);
    localparam longint unsigned MAX_VAL = pow10(DIGITS) - 64'd1;

    seq_state_t       state_r;
    logic [WIDTH-1:0] a_r, b_r;
    logic [1:0]       sel_r;
    logic [BW-1:0]    bcd_a_r, bcd_b_r;
    logic [DIW-1:0]   msd_a_r, msd_b_r, dig_idx_r;
    logic [TW-1:0]    tmr_r;
    logic [WW-1:0]    wait_r;
    logic [3:0]       cmd_r;
    logic             req_ready_r, busy_r, done_r, result_ok_r, req_error_r;

    logic             bad_s;
    logic             conv_start_s, conv_done_s;
    logic [WIDTH-1:0] conv_bin_s;
    logic [BW-1:0]    conv_bcd_s;
    logic [DIW-1:0]   msd_s;
    logic             key_last_s, hold_next_s;
    logic [3:0]       cur_code_s, nxt_code_s;
    seq_state_t       nxt_state_s;
    logic [DIW-1:0]   nxt_idx_s;

    bin_to_bcd #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_conv (
        .clock (clock),
        .reset (reset),
        .start (conv_start_s),
        .bin   (conv_bin_s),
        .done  (conv_done_s),
        .bcd   (conv_bcd_s)
    );

    // Request legality and converter sequencing: A starts on leaving CHECK, B as soon as A is done.
    always_comb begin
        bad_s = (sel_r == 2'b11) || (64'(a_r) > MAX_VAL) || (64'(b_r) > MAX_VAL);
        if (state_r == ST_CHECK) begin
            conv_bin_s   = a_r;
            conv_start_s = !bad_s;
        end else begin
            conv_bin_s   = b_r;
            conv_start_s = (state_r == ST_CONV_A) && conv_done_s;
        end
    end

    // Most significant non-zero digit index; zero still reports digit 0 so one '0' is sent.
    always_comb begin
        msd_s = '0;
        for (int i = 1; i < DIGITS; i++) begin
            msd_s = (conv_bcd_s[4*i +: 4] != 4'd0) ? DIW'(i) : msd_s;
        end
    end

    // Current key code and the key that follows it once its hold+gap window ends.
    always_comb begin
        key_last_s  = (tmr_r == TW'(KEY_CYC - 1));
        hold_next_s = (tmr_r <  TW'(HOLD_CYCLES - 1));
        cur_code_s  = CMD_NOP;
        nxt_code_s  = CMD_NOP;
        nxt_state_s = state_r;
        nxt_idx_s   = dig_idx_r;
        case (state_r)
            ST_SEND_A: begin
                cur_code_s = bcd_a_r[{dig_idx_r, 2'b00} +: 4];
                if (dig_idx_r == '0) begin
                    nxt_state_s = ST_SEND_OP;
                    nxt_code_s  = op_code(sel_r);
                end else begin
                    nxt_idx_s   = dig_idx_r - DIW'(1);
                    nxt_code_s  = bcd_a_r[{nxt_idx_s, 2'b00} +: 4];
                end
            end
            ST_SEND_OP: begin
                cur_code_s  = op_code(sel_r);
                nxt_state_s = ST_SEND_B;
                nxt_idx_s   = msd_b_r;
                nxt_code_s  = bcd_b_r[{msd_b_r, 2'b00} +: 4];
            end
            ST_SEND_B: begin
                cur_code_s = bcd_b_r[{dig_idx_r, 2'b00} +: 4];
                if (dig_idx_r == '0) begin
                    nxt_state_s = ST_SEND_EQ;
                    nxt_code_s  = CMD_EQ;
                end else begin
                    nxt_idx_s   = dig_idx_r - DIW'(1);
                    nxt_code_s  = bcd_b_r[{nxt_idx_s, 2'b00} +: 4];
                end
            end
            ST_SEND_EQ: begin
                cur_code_s  = CMD_EQ;
                nxt_state_s = ST_WAIT_RES;
                nxt_code_s  = CMD_NOP;
            end
            default: begin
                cur_code_s  = CMD_NOP;
            end
        endcase
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            a_r         <= '0;
            b_r         <= '0;
            sel_r       <= 2'b00;
            bcd_a_r     <= '0;
            bcd_b_r     <= '0;
            msd_a_r     <= '0;
            msd_b_r     <= '0;
            dig_idx_r   <= '0;
            tmr_r       <= '0;
            wait_r      <= '0;
            cmd_r       <= CMD_NOP;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            result_ok_r <= 1'b0;
            req_error_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        a_r         <= op_a;
                        b_r         <= op_b;
                        sel_r       <= op_sel;
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        result_ok_r <= 1'b0;
                        req_error_r <= 1'b0;
                        state_r     <= ST_CHECK;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (bad_s) begin
                        state_r     <= ST_FINISH;
                        done_r      <= 1'b1;
                        result_ok_r <= 1'b0;
                        req_error_r <= 1'b1;
                    end else begin
                        state_r     <= ST_CONV_A;
                    end
                end
                ST_CONV_A: begin
                    if (conv_done_s) begin
                        bcd_a_r <= conv_bcd_s;
                        msd_a_r <= msd_s;
                        state_r <= ST_CONV_B;
                    end else begin
                        state_r <= ST_CONV_A;
                    end
                end
                ST_CONV_B: begin
                    if (conv_done_s) begin
                        bcd_b_r   <= conv_bcd_s;
                        msd_b_r   <= msd_s;
                        dig_idx_r <= msd_a_r;
                        tmr_r     <= '0;
                        cmd_r     <= bcd_a_r[{msd_a_r, 2'b00} +: 4];
                        state_r   <= ST_SEND_A;
                    end else begin
                        state_r   <= ST_CONV_B;
                    end
                end
                ST_SEND_A, ST_SEND_OP, ST_SEND_B, ST_SEND_EQ: begin
                    if (key_last_s) begin
                        tmr_r     <= '0;
                        wait_r    <= '0;
                        cmd_r     <= nxt_code_s;
                        dig_idx_r <= nxt_idx_s;
                        state_r   <= nxt_state_s;
                    end else begin
                        tmr_r     <= tmr_r + TW'(1);
                        cmd_r     <= hold_next_s ? cur_code_s : CMD_NOP;
                    end
                end
                ST_WAIT_RES: begin
                    cmd_r <= CMD_NOP;
                    case (status)
                        STAT_DONE: begin
                            state_r     <= ST_FINISH;
                            done_r      <= 1'b1;
                            result_ok_r <= 1'b1;
                            req_error_r <= 1'b0;
                        end
                        STAT_ERR: begin
                            state_r     <= ST_FINISH;
                            done_r      <= 1'b1;
                            result_ok_r <= 1'b0;
                            req_error_r <= 1'b0;
                        end
                        default: begin
                            if (wait_r == WW'(RESULT_TIMEOUT - 1)) begin
                                state_r     <= ST_FINISH;
                                done_r      <= 1'b1;
                                result_ok_r <= 1'b0;
                                req_error_r <= 1'b1;
                            end else begin
                                wait_r      <= wait_r + WW'(1);
                            end
                        end
                    endcase
                end
                ST_FINISH: begin
                    state_r     <= ST_IDLE;
                    req_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    tmr_r       <= '0;
                    wait_r      <= '0;
                    cmd_r       <= CMD_NOP;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    req_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    cmd_r       <= CMD_NOP;
                end
            endcase
        end
    end

    assign cmd       = cmd_r;
    assign req_ready = req_ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign result_ok = result_ok_r;
    assign req_error = req_error_r;

endmodule
